// File: rtl/lpif_dstrm_credit_gate_if.sv
// Flit/credit bundle between the adapter-side feeder and the LPIF master top.
// slave = credit gate view, master = upstream source / environment view.
interface lpif_dstrm_credit_gate_if #(
  parameter int DATA_WIDTH   = 256,
  parameter int FIFO_DEPTH   = 4,
  parameter int CREDIT_WIDTH = 8
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic                    tx_online;
  logic [CREDIT_WIDTH-1:0] init_downstream_credit;
  logic                    credit_return;

  logic                    in_valid;
  logic                    in_ready;
  logic [3:0]              in_state;
  logic [1:0]              in_protid;
  logic [DATA_WIDTH-1:0]   in_data;
  logic                    in_dvalid;
  logic [7:0]              in_crc;
  logic                    in_crc_valid;

  logic [3:0]              dstrm_state;
  logic [1:0]              dstrm_protid;
  logic [DATA_WIDTH-1:0]   dstrm_data;
  logic                    dstrm_dvalid;
  logic [7:0]              dstrm_crc;
  logic                    dstrm_crc_valid;
  logic                    dstrm_valid;

  logic [CREDIT_WIDTH-1:0] credit_count;
  logic [LVL_W-1:0]        fifo_level;
  logic                    credit_err;

  modport slave (
    input  tx_online, init_downstream_credit, credit_return,
    input  in_valid, in_state, in_protid, in_data, in_dvalid, in_crc, in_crc_valid,
    output in_ready,
    output dstrm_state, dstrm_protid, dstrm_data, dstrm_dvalid, dstrm_crc,
    output dstrm_crc_valid, dstrm_valid,
    output credit_count, fifo_level, credit_err
  );

  modport master (
    output tx_online, init_downstream_credit, credit_return,
    output in_valid, in_state, in_protid, in_data, in_dvalid, in_crc, in_crc_valid,
    input  in_ready,
    input  dstrm_state, dstrm_protid, dstrm_data, dstrm_dvalid, dstrm_crc,
    input  dstrm_crc_valid, dstrm_valid,
    input  credit_count, fifo_level, credit_err
  );
endinterface

// File: rtl/lpif_dstrm_credit_gate.sv
// Flit FIFO + downstream credit gate feeding the LPIF master top dstrm_* inputs.
// Define LPIF_DSTRM_CRC_GEN_EN to generate dstrm_crc (CRC-8/0x07) instead of passing in_crc through.
module lpif_dstrm_credit_gate #(
  parameter int DATA_WIDTH   = 256,
  parameter int FIFO_DEPTH   = 4,
  parameter int CREDIT_WIDTH = 8
) (
  input logic clk_wr,
  input logic rst_wr,
  lpif_dstrm_credit_gate_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic {OFFLINE = 1'b0, ONLINE = 1'b1} fsm_t;

  typedef struct packed {
    logic [3:0]            state;
    logic [1:0]            protid;
    logic [DATA_WIDTH-1:0] data;
    logic                  dvalid;
    logic [7:0]            crc;
    logic                  crc_valid;
  } entry_t;

  entry_t mem_q [FIFO_DEPTH];

  fsm_t                    fsm_q, fsm_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]        level_q, level_d;
  logic [CREDIT_WIDTH-1:0] credit_q, credit_d;
  logic                    err_q, err_d;

  logic [3:0]              dstrm_state_q, dstrm_state_d;
  logic [1:0]              dstrm_protid_q, dstrm_protid_d;
  logic [DATA_WIDTH-1:0]   dstrm_data_q, dstrm_data_d;
  logic                    dstrm_dvalid_q, dstrm_dvalid_d;
  logic [7:0]              dstrm_crc_q, dstrm_crc_d;
  logic                    dstrm_crc_valid_q, dstrm_crc_valid_d;
  logic                    dstrm_valid_q, dstrm_valid_d;

  logic   in_ready;
  logic   push, pop;
  entry_t wr_entry, head;
  logic [7:0] head_crc;
  logic       head_crc_valid;

  assign in_ready = (level_q != LVL_W'(FIFO_DEPTH));
  assign push     = bus.in_valid & in_ready;
  assign head     = mem_q[rd_ptr_q];

  assign wr_entry.state     = bus.in_state;
  assign wr_entry.protid    = bus.in_protid;
  assign wr_entry.data      = bus.in_data;
  assign wr_entry.dvalid    = bus.in_dvalid;
  assign wr_entry.crc       = bus.in_crc;
  assign wr_entry.crc_valid = bus.in_crc_valid;

`ifdef LPIF_DSTRM_CRC_GEN_EN
  // Bit-serial CRC-8 unrolled over the head payload, MSB first.
  logic [7:0] crc_chain [DATA_WIDTH+1];
  logic       unused_crc_fields;
  assign crc_chain[0] = 8'h00;
  for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_crc
    assign crc_chain[gi+1] = {crc_chain[gi][6:0], 1'b0}
                           ^ ({8{crc_chain[gi][7] ^ head.data[DATA_WIDTH-1-gi]}} & 8'h07);
  end
  assign head_crc          = crc_chain[DATA_WIDTH];
  assign head_crc_valid    = head.dvalid;
  assign unused_crc_fields = ^{head.crc, head.crc_valid};
`else
  assign head_crc       = head.crc;
  assign head_crc_valid = head.crc_valid;
`endif

  always_comb begin
    fsm_d             = fsm_q;
    credit_d          = credit_q;
    err_d             = err_q;
    pop               = 1'b0;
    dstrm_state_d     = dstrm_state_q;
    dstrm_protid_d    = dstrm_protid_q;
    dstrm_data_d      = '0;
    dstrm_dvalid_d    = 1'b0;
    dstrm_crc_d       = 8'h00;
    dstrm_crc_valid_d = 1'b0;
    dstrm_valid_d     = 1'b0;

    case (fsm_q)
      OFFLINE: begin
        credit_d = '0;
        if (bus.tx_online) begin
          fsm_d    = ONLINE;
          credit_d = bus.init_downstream_credit;
        end
      end
      ONLINE: begin
        if (!bus.tx_online) begin
          fsm_d    = OFFLINE;
          credit_d = '0;
        end else begin
          pop = (level_q != '0) && (credit_q != '0);
          if (pop && !bus.credit_return) begin
            credit_d = credit_q - 1'b1;
          end else if (!pop && bus.credit_return) begin
            // A return at a saturated count is dropped and flagged.
            if (&credit_q) err_d = 1'b1;
            else           credit_d = credit_q + 1'b1;
          end
        end
      end
      default: fsm_d = OFFLINE;
    endcase

    if (pop) begin
      dstrm_state_d     = head.state;
      dstrm_protid_d    = head.protid;
      dstrm_data_d      = head.data;
      dstrm_dvalid_d    = head.dvalid;
      dstrm_crc_d       = head_crc;
      dstrm_crc_valid_d = head_crc_valid;
      dstrm_valid_d     = 1'b1;
    end

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
  end

  always_ff @(posedge clk_wr) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end

  always_ff @(posedge clk_wr) begin
    if (rst_wr) begin
      fsm_q             <= OFFLINE;
      wr_ptr_q          <= '0;
      rd_ptr_q          <= '0;
      level_q           <= '0;
      credit_q          <= '0;
      err_q             <= 1'b0;
      dstrm_state_q     <= '0;
      dstrm_protid_q    <= '0;
      dstrm_data_q      <= '0;
      dstrm_dvalid_q    <= 1'b0;
      dstrm_crc_q       <= 8'h00;
      dstrm_crc_valid_q <= 1'b0;
      dstrm_valid_q     <= 1'b0;
    end else begin
      fsm_q             <= fsm_d;
      wr_ptr_q          <= wr_ptr_d;
      rd_ptr_q          <= rd_ptr_d;
      level_q           <= level_d;
      credit_q          <= credit_d;
      err_q             <= err_d;
      dstrm_state_q     <= dstrm_state_d;
      dstrm_protid_q    <= dstrm_protid_d;
      dstrm_data_q      <= dstrm_data_d;
      dstrm_dvalid_q    <= dstrm_dvalid_d;
      dstrm_crc_q       <= dstrm_crc_d;
      dstrm_crc_valid_q <= dstrm_crc_valid_d;
      dstrm_valid_q     <= dstrm_valid_d;
    end
  end

  assign bus.in_ready        = in_ready;
  assign bus.dstrm_state     = dstrm_state_q;
  assign bus.dstrm_protid    = dstrm_protid_q;
  assign bus.dstrm_data      = dstrm_data_q;
  assign bus.dstrm_dvalid    = dstrm_dvalid_q;
  assign bus.dstrm_crc       = dstrm_crc_q;
  assign bus.dstrm_crc_valid = dstrm_crc_valid_q;
  assign bus.dstrm_valid     = dstrm_valid_q;
  assign bus.credit_count    = credit_q;
  assign bus.fifo_level      = level_q;
  assign bus.credit_err      = err_q;
endmodule

// File: tb/tb_lpif_dstrm_credit_gate.sv
// Directed bench for lpif_dstrm_credit_gate: per-cycle vector table plus
// hand-written saturation, mid-operation reset and CRC-generation sequences.
module tb_lpif_dstrm_credit_gate;
  localparam int DW = 256;
  localparam int FD = 4;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lpif_dstrm_credit_gate_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD), .CREDIT_WIDTH(CW)) bus ();

  lpif_dstrm_credit_gate #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD), .CREDIT_WIDTH(CW)) dut (
    .clk_wr (clk),
    .rst_wr (rst),
    .bus    (bus)
  );

  typedef struct {
    logic       tx;
    logic [7:0] init;
    logic       ret;
    logic       push;
    logic [7:0] dat;
    logic       e_valid;
    logic [7:0] e_data;
    logic [7:0] e_credit;
    logic [2:0] e_level;
    logic       e_ready;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t v(input logic tx, input logic [7:0] init, input logic ret,
                             input logic push, input logic [7:0] dat,
                             input logic e_valid, input logic [7:0] e_data,
                             input logic [7:0] e_credit, input logic [2:0] e_level,
                             input logic e_ready);
    vec_t r;
    r.tx = tx; r.init = init; r.ret = ret; r.push = push; r.dat = dat;
    r.e_valid = e_valid; r.e_data = e_data; r.e_credit = e_credit;
    r.e_level = e_level; r.e_ready = e_ready;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Pushed flits carry state=dat[3:0], protid=dat[1:0], crc=dat^0x3C, both valids set.
  task automatic drive(input logic tx, input logic [7:0] init, input logic ret,
                       input logic push, input logic [7:0] dat);
    bus.tx_online              = tx;
    bus.init_downstream_credit = init;
    bus.credit_return          = ret;
    bus.in_valid               = push;
    bus.in_data                = DW'(dat);
    bus.in_state               = dat[3:0];
    bus.in_protid              = dat[1:0];
    bus.in_dvalid              = 1'b1;
    bus.in_crc                 = dat ^ 8'h3C;
    bus.in_crc_valid           = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] last_state;
    logic [1:0] last_protid;

    drive(1'b1, 8'd5, 1'b0, 1'b1, 8'h33);
    drive(1'b1, 8'd5, 1'b0, 1'b1, 8'h34);
    check("reset_valid",  64'(bus.dstrm_valid), 64'd0);
    check("reset_data",   bus.dstrm_data[63:0], 64'd0);
    check("reset_credit", 64'(bus.credit_count), 64'd0);
    check("reset_level",  64'(bus.fifo_level), 64'd0);
    check("reset_ready",  64'(bus.in_ready), 64'd1);
    check("reset_err",    64'(bus.credit_err), 64'd0);
    check("reset_state",  64'(bus.dstrm_state), 64'd0);
    rst = 1'b0;

    //                tx init ret push dat | valid data cred lvl rdy
    vecs.push_back(v(1, 3, 0, 0,  0,   0,  0, 3, 0, 1));
    vecs.push_back(v(1, 3, 0, 1,  1,   0,  0, 3, 1, 1));
    vecs.push_back(v(1, 3, 0, 1,  2,   1,  1, 2, 1, 1));
    vecs.push_back(v(1, 3, 0, 1,  3,   1,  2, 1, 1, 1));
    vecs.push_back(v(1, 3, 0, 1,  4,   1,  3, 0, 1, 1));
    vecs.push_back(v(1, 3, 0, 1,  5,   0,  0, 0, 2, 1));
    vecs.push_back(v(1, 3, 0, 0,  0,   0,  0, 0, 2, 1));
    vecs.push_back(v(1, 3, 1, 0,  0,   0,  0, 1, 2, 1));
    vecs.push_back(v(1, 3, 0, 0,  0,   1,  4, 0, 1, 1));
    vecs.push_back(v(1, 3, 1, 0,  0,   0,  0, 1, 1, 1));
    vecs.push_back(v(1, 3, 0, 0,  0,   1,  5, 0, 0, 1));
    vecs.push_back(v(1, 3, 0, 0,  0,   0,  0, 0, 0, 1));
    vecs.push_back(v(0, 0, 0, 0,  0,   0,  0, 0, 0, 1));
    vecs.push_back(v(0, 0, 0, 1, 11,   0,  0, 0, 1, 1));
    vecs.push_back(v(0, 0, 0, 1, 12,   0,  0, 0, 2, 1));
    vecs.push_back(v(0, 0, 0, 1, 13,   0,  0, 0, 3, 1));
    vecs.push_back(v(0, 0, 0, 1, 14,   0,  0, 0, 4, 0));
    vecs.push_back(v(0, 0, 0, 1, 99,   0,  0, 0, 4, 0));
    vecs.push_back(v(1, 8, 0, 0,  0,   0,  0, 8, 4, 0));
    vecs.push_back(v(1, 8, 0, 0,  0,   1, 11, 7, 3, 1));
    vecs.push_back(v(1, 8, 0, 0,  0,   1, 12, 6, 2, 1));
    vecs.push_back(v(1, 8, 0, 0,  0,   1, 13, 5, 1, 1));
    vecs.push_back(v(1, 8, 0, 0,  0,   1, 14, 4, 0, 1));
    vecs.push_back(v(1, 8, 0, 0,  0,   0,  0, 4, 0, 1));
    vecs.push_back(v(0, 0, 0, 0,  0,   0,  0, 0, 0, 1));
    vecs.push_back(v(1, 1, 0, 0,  0,   0,  0, 1, 0, 1));
    vecs.push_back(v(1, 1, 0, 1, 21,   0,  0, 1, 1, 1));
    vecs.push_back(v(1, 1, 1, 1, 22,   1, 21, 1, 1, 1));
    vecs.push_back(v(1, 1, 1, 1, 23,   1, 22, 1, 1, 1));
    vecs.push_back(v(1, 1, 1, 1, 24,   1, 23, 1, 1, 1));
    vecs.push_back(v(0, 1, 1, 1, 25,   0,  0, 0, 2, 1));
    vecs.push_back(v(0, 0, 0, 0,  0,   0,  0, 0, 2, 1));
    vecs.push_back(v(1, 2, 0, 0,  0,   0,  0, 2, 2, 1));
    vecs.push_back(v(1, 2, 0, 0,  0,   1, 24, 1, 1, 1));
    vecs.push_back(v(1, 2, 0, 0,  0,   1, 25, 0, 0, 1));

    last_state  = 4'd0;
    last_protid = 2'd0;
    for (int i = 0; i < vecs.size(); i++) begin
      vec_t r;
      r = vecs[i];
      drive(r.tx, r.init, r.ret, r.push, r.dat);
      if (r.e_valid) begin
        last_state  = r.e_data[3:0];
        last_protid = r.e_data[1:0];
      end
      check($sformatf("row%0d_valid", i),  64'(bus.dstrm_valid), 64'(r.e_valid));
      check($sformatf("row%0d_data", i),   bus.dstrm_data[63:0], 64'(r.e_data));
      check($sformatf("row%0d_credit", i), 64'(bus.credit_count), 64'(r.e_credit));
      check($sformatf("row%0d_level", i),  64'(bus.fifo_level), 64'(r.e_level));
      check($sformatf("row%0d_ready", i),  64'(bus.in_ready), 64'(r.e_ready));
      check($sformatf("row%0d_dvalid", i), 64'(bus.dstrm_dvalid), 64'(r.e_valid));
      check($sformatf("row%0d_crcv", i),   64'(bus.dstrm_crc_valid), 64'(r.e_valid));
      check($sformatf("row%0d_state", i),  64'(bus.dstrm_state), 64'(last_state));
      check($sformatf("row%0d_protid", i), 64'(bus.dstrm_protid), 64'(last_protid));
`ifndef LPIF_DSTRM_CRC_GEN_EN
      check($sformatf("row%0d_crc", i), 64'(bus.dstrm_crc),
            r.e_valid ? 64'(r.e_data ^ 8'h3C) : 64'd0);
`endif
      $display("row %0d: valid=%0d data=%0d credit=%0d level=%0d ready=%0d", i,
               bus.dstrm_valid, bus.dstrm_data[7:0], bus.credit_count,
               bus.fifo_level, bus.in_ready);
    end
    check("table_err", 64'(bus.credit_err), 64'd0);

    // Saturated credit: return is dropped, error is sticky.
    drive(1'b0, 8'd0,   1'b0, 1'b0, 8'd0);
    drive(1'b1, 8'd255, 1'b0, 1'b0, 8'd0);
    check("sat_load", 64'(bus.credit_count), 64'd255);
    drive(1'b1, 8'd255, 1'b1, 1'b0, 8'd0);
    check("sat_credit", 64'(bus.credit_count), 64'd255);
    check("sat_err",    64'(bus.credit_err), 64'd1);
    for (int k = 0; k < 3; k++) drive(1'b1, 8'd255, 1'b0, 1'b0, 8'd0);
    check("sat_err_sticky", 64'(bus.credit_err), 64'd1);
    $display("saturation: credit=%0d err=%0d", bus.credit_count, bus.credit_err);

    // Reset in the middle of traffic while the link stays online.
    drive(1'b1, 8'd255, 1'b0, 1'b1, 8'h41);
    drive(1'b1, 8'd255, 1'b0, 1'b1, 8'h42);
    check("mid_pop_data", bus.dstrm_data[63:0], 64'h41);
    check("mid_pop_credit", 64'(bus.credit_count), 64'd254);
    rst = 1'b1;
    drive(1'b1, 8'd255, 1'b0, 1'b1, 8'h43);
    check("rst_mid_valid",  64'(bus.dstrm_valid), 64'd0);
    check("rst_mid_data",   bus.dstrm_data[63:0], 64'd0);
    check("rst_mid_level",  64'(bus.fifo_level), 64'd0);
    check("rst_mid_credit", 64'(bus.credit_count), 64'd0);
    check("rst_mid_err",    64'(bus.credit_err), 64'd0);
    check("rst_mid_state",  64'(bus.dstrm_state), 64'd0);
    check("rst_mid_ready",  64'(bus.in_ready), 64'd1);
    rst = 1'b0;
    drive(1'b0, 8'd0, 1'b0, 1'b0, 8'd0);
    check("rst_mid_fifo_empty", 64'(bus.fifo_level), 64'd0);
    $display("mid reset: level=%0d credit=%0d", bus.fifo_level, bus.credit_count);

`ifdef LPIF_DSTRM_CRC_GEN_EN
    // Generated CRC: data 0 -> 0x00, data 1 -> 0x07; in_crc forced to 0xAA.
    drive(1'b1, 8'd4, 1'b0, 1'b0, 8'd0);
    bus.in_crc = 8'hAA;
    bus.tx_online = 1'b1; bus.in_valid = 1'b1; bus.in_data = DW'(0); bus.in_dvalid = 1'b1;
    bus.in_crc_valid = 1'b0;
    @(posedge clk); #1;
    bus.in_data = DW'(1); bus.in_crc = 8'hAA; bus.in_crc_valid = 1'b0;
    @(posedge clk); #1;
    check("crc_gen0_valid", 64'(bus.dstrm_valid), 64'd1);
    check("crc_gen0",       64'(bus.dstrm_crc), 64'h00);
    check("crc_gen0_v",     64'(bus.dstrm_crc_valid), 64'd1);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("crc_gen1_data",  bus.dstrm_data[63:0], 64'd1);
    check("crc_gen1",       64'(bus.dstrm_crc), 64'h07);
    check("crc_gen1_v",     64'(bus.dstrm_crc_valid), 64'd1);
    $display("crc gen: crc=%0h", bus.dstrm_crc);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lpif_dstrm_credit_gate.md
Name: lpif_dstrm_credit_gate

Overview:
- Upstream feeder for the x8 asym1 full LPIF master top; drives its dstrm_* inputs.
- Buffers adapter-side LPIF flits in a small FIFO.
- Releases one flit per cycle onto dstrm_* only while the link is online and downstream credit is available.
- Owns the downstream credit counter: loaded from init_downstream_credit at link-up, decremented per issued flit, replenished by credit_return pulses.

Parameters:
- DATA_WIDTH, 256, flit payload width (in_data/dstrm_data).
- FIFO_DEPTH, 4, flit FIFO entries; power of two, minimum 2.
- CREDIT_WIDTH, 8, credit counter width; must match init_downstream_credit.

Ports:
- clk_wr  in  1  single clock.
- rst_wr  in  1  reset, synchronous, active-high.
- tx_online  in  1  link online (post auto-sync delay).
- init_downstream_credit  in  CREDIT_WIDTH  credits loaded at link-up.
- credit_return  in  1  one-cycle pulse = +1 credit.
- in_valid  in  1  flit offered.
- in_ready  out  1  FIFO can accept.
- in_state  in  4  LPIF state.
- in_protid  in  2  protocol id.
- in_data  in  DATA_WIDTH  payload.
- in_dvalid  in  1  payload valid.
- in_crc  in  8  CRC.
- in_crc_valid  in  1  CRC valid.
- dstrm_state / dstrm_protid / dstrm_data / dstrm_dvalid / dstrm_crc / dstrm_crc_valid / dstrm_valid  out  4/2/DATA_WIDTH/1/8/1/1  registered flit to master top.
- credit_count  out  CREDIT_WIDTH  current credits.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  occupancy.
- credit_err  out  1  sticky: return arrived at saturated count.

Behaviour:
- Reset (rst_wr=1 at clk_wr edge):
  - FSM=OFFLINE; FIFO empty; credit_count=0; credit_err=0.
  - All dstrm_* = 0.
  - in_ready=1 in the first cycle after reset.
- in_ready = (fifo_level != FIFO_DEPTH), combinational from count.
- Push = in_valid & in_ready; stores {state, protid, data, dvalid, crc, crc_valid}.
- FSM states:
  - OFFLINE:
    - No pops; credit_count held at 0; pushes still accepted until full.
    - tx_online sampled 1 -> ONLINE; same edge credit_count <= init_downstream_credit.
    - credit_return ignored in OFFLINE.
  - ONLINE:
    - Pop when FIFO non-empty and credit_count != 0.
    - tx_online sampled 0 -> OFFLINE next edge; that edge does no pop, clears credit_count to 0, and retains FIFO contents.
- Pop edge:
  - dstrm_* <= head entry; dstrm_valid <= 1; read pointer advances.
  - Non-pop edge: dstrm_valid, dstrm_dvalid, dstrm_crc_valid <= 0; dstrm_data <= 0; dstrm_crc <= 0; dstrm_state/dstrm_protid hold last issued values.
- Latency:
  - Push at edge N into an empty FIFO with credit>0 while ONLINE -> pop at edge N+1 -> dstrm_valid high in the cycle after edge N+1.
  - Steady throughput 1 flit/cycle.
- Credit arithmetic, per edge in ONLINE:
  - pop & !return: -1.
  - !pop & return: +1.
  - pop & return: unchanged.
  - return with count at all-ones: count stays all-ones, credit_err <= 1.
  - Credit never underflows; pop is gated by count != 0.
- Simultaneous push and pop:
  - Both occur; level unchanged.
  - Push into an empty FIFO is not poppable on the same edge (no bypass).
- Full FIFO: in_ready=0; in_valid ignored; no data loss for the source.
- Pointers wrap modulo FIFO_DEPTH; level distinguishes full from empty.
- Reset mid-operation: FIFO contents discarded, credits zeroed, dstrm_* zeroed next edge regardless of tx_online.
- credit_err clears only on reset.

Optional Feature:
- Macro LPIF_DSTRM_CRC_GEN_EN.
- Defined:
  - in_crc and in_crc_valid are ignored.
  - At pop, dstrm_crc <= CRC-8 (poly 0x07, init 0x00, MSB-first) over the popped dstrm_data; dstrm_crc_valid <= popped dvalid.
  - CRC is combinational on the FIFO head; latency unchanged.
- Undefined: crc fields pass through from the FIFO unchanged.

Test Plan:
- Reset, then tx_online=1, init_downstream_credit=3; push 5 flits (data=1..5) back-to-back -> dstrm_valid high for exactly 3 cycles carrying 1,2,3; credit_count=0; fifo_level=2.
- Continue from above; pulse credit_return twice -> flits 4,5 issued, one per return, each issued in the cycle after the edge sampling its return; credit_count ends 0.
- tx_online=0; push 4 flits -> in_ready deasserts after the 4th; dstrm_valid stays 0; then tx_online=1, init=8 -> 4 flits issue on 4 consecutive cycles in order; credit_count=4.
- credit=255 in ONLINE, FIFO empty, one credit_return pulse -> credit_count stays 255; credit_err=1 until reset.
- Continuous push with credit_return every cycle, init=1 -> sustained 1 flit/cycle; credit_count stays 1; tx_online drop mid-stream -> issue stops next edge, credit_count=0, remaining flits retained.
- With LPIF_DSTRM_CRC_GEN_EN, issue data=0 and data=1 with dvalid=1 -> dstrm_crc=0x00 then 0x07, dstrm_crc_valid=1; in_crc=0xAA ignored.
